// File: rtl/modsq_carry_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modsq_pkg
// Purpose  : Shared definitions for the modular-squaring carry resolver.
//            Holds the width derivation helpers, the default coefficient,
//            word and carry types, and the resolver FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package modsq_pkg;

  // Width derivation helpers, usable in parameter defaults.
  function automatic int num_elements(input int mod_len, input int word_len,
                                      input int redundant);
    return (mod_len / word_len) + redundant;
  endfunction

  function automatic int coef_bits(input int word_len);
    return 2 * word_len;
  endfunction

  // A coefficient plus a carry fits in COEF_BITS+1 bits, so after dropping
  // WORD_LEN bits the carry needs COEF_BITS-WORD_LEN+1 bits.
  function automatic int carry_bits(input int word_len, input int coef_w);
    return coef_w - word_len + 1;
  endfunction

  localparam int DEF_MOD_LEN       = 1024;
  localparam int DEF_WORD_LEN      = 16;
  localparam int DEF_REDUNDANT     = 2;
  localparam int DEF_NUM_ELEMENTS  = num_elements(DEF_MOD_LEN, DEF_WORD_LEN, DEF_REDUNDANT);
  localparam int DEF_COEF_BITS     = coef_bits(DEF_WORD_LEN);

  typedef logic [DEF_COEF_BITS-1:0]             coef_t;
  typedef logic [DEF_WORD_LEN-1:0]              word_t;
  typedef logic [DEF_COEF_BITS-DEF_WORD_LEN:0]  carry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/modsq_carry_resolve_lane_adder.sv
`default_nettype none
// ============================================================================
// Module   : carry_lane_adder
// Purpose  : One combinational carry-resolve lane: adds the incoming carry to
//            a redundant coefficient, emits the low WORD_LEN bits as the
//            normalized word and the remaining upper bits as the next carry.
// Ports    : coefficient - redundant coefficient (COEF_BITS)
//            carry_in    - carry from the previous lane / cycle
//            word        - normalized output word (WORD_LEN)
//            carry_out   - carry into the next lane / cycle
// Revision : 1.0 - initial release
// ============================================================================
module carry_lane_adder #(
  parameter int WORD_LEN   = 16,
  parameter int COEF_BITS  = 2 * WORD_LEN,
  parameter int CARRY_BITS = COEF_BITS - WORD_LEN + 1
) (
  input  logic [COEF_BITS-1:0]  coefficient,
  input  logic [CARRY_BITS-1:0] carry_in,
  output logic [WORD_LEN-1:0]   word,
  output logic [CARRY_BITS-1:0] carry_out
);

  logic [COEF_BITS:0] w_acc;
  logic [COEF_BITS:0] w_carry_ext;

  assign w_carry_ext = {{(COEF_BITS + 1 - CARRY_BITS){1'b0}}, carry_in};
  assign w_acc       = {1'b0, coefficient} + w_carry_ext;
  assign word        = w_acc[WORD_LEN-1:0];
  assign carry_out   = w_acc[COEF_BITS:WORD_LEN];

endmodule
`default_nettype wire

// File: rtl/modsq_carry_resolve.sv
`default_nettype none
// ============================================================================
// Module   : modsq_carry_resolve
// Purpose  : Converts the redundant coefficient vector from the modular
//            squaring wrapper into a normalized nonredundant integer by
//            rippling carries word-serially, LANES coefficients per cycle.
//            No modular reduction: out = sum(c_j * 2^(WORD_LEN*j)).
// Ports    : clk, reset     - clock, synchronous active-high reset
//            in_valid/ready - coefficient vector handshake
//            in_coeffs      - coefficient j at [j*COEF_BITS +: COEF_BITS]
//            out_valid/ready- result handshake
//            out_value      - word j at [j*WORD_LEN +: WORD_LEN]
//            out_carry      - bits above the top word
//            busy           - high while resolving or holding a result
// Revision : 1.0 - initial release
// ============================================================================
module modsq_carry_resolve
  import modsq_pkg::*;
#(
  parameter int MOD_LEN               = 1024,
  parameter int WORD_LEN              = 16,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
  parameter int COEF_BITS             = coef_bits(WORD_LEN),
  parameter int LANES                 = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [NUM_ELEMENTS*COEF_BITS-1:0]  in_coeffs,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_ELEMENTS*WORD_LEN-1:0]   out_value,
  output logic [COEF_BITS-WORD_LEN:0]        out_carry,
  output logic                               busy
);

  localparam int IN_W       = NUM_ELEMENTS * COEF_BITS;
  localparam int OUT_W      = NUM_ELEMENTS * WORD_LEN;
  localparam int CARRY_BITS = carry_bits(WORD_LEN, COEF_BITS);
  localparam int STEPS      = NUM_ELEMENTS / LANES;
  localparam int CNT_W      = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(STEPS - 1);

  if ((NUM_ELEMENTS % LANES) != 0) begin : g_lanes_check
    $error("LANES must divide NUM_ELEMENTS");
  end

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IN_W-1:0]           r_coef;
  logic [CARRY_BITS-1:0]     r_carry;
  logic [CNT_W-1:0]          r_step;
  logic [OUT_W-1:0]          r_value;
  logic [CARRY_BITS-1:0]     r_out_carry;

  logic                      w_accept;
  logic                      w_run;
  logic                      w_last;
  logic [LANES*WORD_LEN-1:0] w_words;
  logic [CARRY_BITS-1:0]     w_carry [LANES+1];
  logic [OUT_W-1:0]          w_value_nxt;

  // Lane chain: lane k consumes the k-th lowest unprocessed coefficient and
  // hands its carry to lane k+1 within the same cycle.
  assign w_carry[0] = r_carry;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    carry_lane_adder #(
      .WORD_LEN   (WORD_LEN),
      .COEF_BITS  (COEF_BITS),
      .CARRY_BITS (CARRY_BITS)
    ) u_lane (
      .coefficient (r_coef[k*COEF_BITS +: COEF_BITS]),
      .carry_in    (w_carry[k]),
      .word        (w_words[k*WORD_LEN +: WORD_LEN]),
      .carry_out   (w_carry[k+1])
    );
  end

  // Resolved words enter at the top and the register shifts down; after
  // STEPS cycles every word has landed at its own index, so no indexed write
  // mux is needed.
  assign w_value_nxt = OUT_W'({w_words, r_value} >> (LANES * WORD_LEN));
  assign w_last      = (r_step == C_LAST_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        w_run = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_coef      <= '0;
      r_carry     <= '0;
      r_step      <= '0;
      r_value     <= '0;
      r_out_carry <= '0;
    end else if (w_accept) begin
      r_coef  <= in_coeffs;
      r_carry <= '0;
      r_step  <= '0;
    end else if (w_run) begin
      r_coef  <= r_coef >> (LANES * COEF_BITS);
      r_carry <= w_carry[LANES];
      r_step  <= r_step + CNT_W'(1);
      r_value <= w_value_nxt;
      if (w_last) begin
        r_out_carry <= w_carry[LANES];
      end
    end
  end

  assign out_value = r_value;
  assign out_carry = r_out_carry;

endmodule
`default_nettype wire

// File: tb/tb_modsq_carry_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_modsq_carry_resolve
// Purpose  : Self-checking bench for modsq_carry_resolve (LANES 1, 2, 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_modsq_carry_resolve;

  localparam int NE    = 66;
  localparam int WL    = 16;
  localparam int CBW   = 32;
  localparam int KB    = CBW - WL + 1;
  localparam int IN_W  = NE * CBW;
  localparam int OUT_W = NE * WL;

  typedef struct packed {
    logic [OUT_W-1:0] v;
    logic [KB-1:0]    c;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [IN_W-1:0]  in_coeffs;
  logic             in_valid, in_valid2, in_valid3;
  logic             out_ready, out_ready2, out_ready3;
  logic             in_ready, in_ready2, in_ready3;
  logic             out_valid, out_valid2, out_valid3;
  logic             busy, busy2, busy3;
  logic [OUT_W-1:0] out_value, out_value2, out_value3;
  logic [KB-1:0]    out_carry, out_carry2, out_carry3;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  modsq_carry_resolve #(.LANES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_coeffs(in_coeffs),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_carry(out_carry), .busy(busy));

  modsq_carry_resolve #(.LANES(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_coeffs(in_coeffs),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_value(out_value2), .out_carry(out_carry2), .busy(busy2));

  modsq_carry_resolve #(.LANES(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_coeffs(in_coeffs),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_value(out_value3), .out_carry(out_carry3), .busy(busy3));

  // Reference: exact wide-integer sum of c_j * 2^(16*j).
  function automatic exp_t model(input logic [IN_W-1:0] v);
    logic [OUT_W+KB-1:0] acc;
    logic [OUT_W+KB-1:0] term;
    exp_t r;
    acc = '0;
    for (int j = 0; j < NE; j++) begin
      term = '0;
      term[CBW-1:0] = v[j*CBW +: CBW];
      acc = acc + (term << (WL * j));
    end
    r.v = acc[OUT_W-1:0];
    r.c = acc[OUT_W +: KB];
    return r;
  endfunction

  task automatic check_bits(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_value(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    int first;
    first = -1;
    for (int j = NE - 1; j >= 0; j--)
      if (obs[j*WL +: WL] !== exp[j*WL +: WL]) first = j;
    if (first < 0) first = 0;
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: word %0d observed %h expected %h", tag, first,
             obs[first*WL +: WL], exp[first*WL +: WL]);
    end
  endtask

  // Pops the oldest expected result and compares it with the DONE outputs.
  task automatic check_result(input string tag);
    exp_t e;
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_bits({tag, "_valid"}, 64'(out_valid), 64'd1);
      check_value({tag, "_value"}, out_value, e.v);
      check_bits({tag, "_carry"}, 64'(out_carry), 64'(e.c));
    end
  endtask

  task automatic start_vec(input logic [IN_W-1:0] v);
    in_coeffs = v;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ready_low);
    lat = 0;
    ready_low = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_run(input string tag, input logic [IN_W-1:0] v);
    int lat;
    bit rl;
    exp_q.push_back(model(v));
    check_bits({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    start_vec(v);
    wait_valid(lat, rl);
    check_bits({tag, "_latency"}, 64'(lat), 64'd66);
    check_bits({tag, "_in_ready_low_run"}, 64'(rl), 64'd1);
    check_result(tag);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bits({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
    check_bits({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [IN_W-1:0] v;
    logic [IN_W-1:0] vb;
    logic [OUT_W-1:0] sv;
    logic [KB-1:0]    sc;
    exp_t e;
    int lat, l1, l2, l3;
    bit rl, ok;

    reset = 1'b1;
    in_valid = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
    out_ready = 1'b0; out_ready2 = 1'b0; out_ready3 = 1'b0;
    in_coeffs = '0;
    repeat (3) @(negedge clk);
    check_bits("rst_in_ready", 64'(in_ready), 64'd1);
    check_bits("rst_out_valid", 64'(out_valid), 64'd0);
    check_bits("rst_busy", 64'(busy), 64'd0);
    check_value("rst_out_value", out_value, '0);
    check_bits("rst_out_carry", 64'(out_carry), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // All-zero vector: full latency, zero result.
    do_run("zero", '0);
    release_out("zero");

    // Single low coefficient spilling past one word.
    v = '0;
    v[31:0] = 32'h0001_FFFF;
    do_run("c0", v);
    check_value("c0_const", out_value, OUT_W'(32'h0001_FFFF));
    release_out("c0");

    // All coefficients 0x0001FFFF.
    for (int j = 0; j < NE; j++) v[j*CBW +: CBW] = 32'h0001_FFFF;
    do_run("all1ffff", v);
    check_bits("all1ffff_w0", 64'(out_value[15:0]), 64'hFFFF);
    check_bits("all1ffff_w1", 64'(out_value[31:16]), 64'h0000);
    check_bits("all1ffff_w2", 64'(out_value[47:32]), 64'h0001);
    check_bits("all1ffff_w65", 64'(out_value[65*WL +: WL]), 64'h0001);
    check_bits("all1ffff_carry", 64'(out_carry), 64'd2);
    release_out("all1ffff");

    // Full-width coefficients: maximum carries.
    for (int j = 0; j < NE; j++) v[j*CBW +: CBW] = 32'hFFFF_FFFF;
    do_run("allff", v);
    release_out("allff");

    // Random full-width coefficients.
    for (int j = 0; j < NE; j++) v[j*CBW +: CBW] = $urandom;
    do_run("rand", v);
    release_out("rand");

    // Top coefficient only, on LANES = 1, 2, 3 together.
    v = '0;
    v[65*CBW +: CBW] = 32'h0003_0000;
    e = model(v);
    exp_q.push_back(e);
    in_coeffs = v;
    in_valid = 1'b1; in_valid2 = 1'b1; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
    l1 = 0; l2 = 0; l3 = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (out_valid  && l1 == 0) l1 = n;
      if (out_valid2 && l2 == 0) l2 = n;
      if (out_valid3 && l3 == 0) l3 = n;
      if (l1 != 0 && l2 != 0 && l3 != 0) break;
    end
    check_bits("top_lat_l1", 64'(l1), 64'd66);
    check_bits("top_lat_l2", 64'(l2), 64'd33);
    check_bits("top_lat_l3", 64'(l3), 64'd22);
    check_bits("top_carry_const", 64'(out_carry), 64'd3);
    check_result("top_l1");
    check_value("top_l2_value", out_value2, e.v);
    check_bits("top_l2_carry", 64'(out_carry2), 64'(e.c));
    check_value("top_l3_value", out_value3, e.v);
    check_bits("top_l3_carry", 64'(out_carry3), 64'(e.c));
    out_ready = 1'b1; out_ready2 = 1'b1; out_ready3 = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready2 = 1'b0; out_ready3 = 1'b0;
    check_bits("top_l2_in_ready", 64'(in_ready2), 64'd1);
    check_bits("top_l3_in_ready", 64'(in_ready3), 64'd1);

    // Backpressure in DONE with a second vector waiting upstream.
    for (int j = 0; j < NE; j++) v[j*CBW +: CBW] = $urandom;
    for (int j = 0; j < NE; j++) vb[j*CBW +: CBW] = $urandom;
    exp_q.push_back(model(v));
    start_vec(v);
    wait_valid(lat, rl);
    check_bits("bp_latency", 64'(lat), 64'd66);
    sv = out_value;
    sc = out_carry;
    in_coeffs = vb;
    in_valid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_value !== sv || out_carry !== sc || in_ready !== 1'b0 || out_valid !== 1'b1)
        ok = 1'b0;
    end
    check_bits("bp_stable", 64'(ok), 64'd1);
    check_result("bp_a");
    exp_q.push_back(model(vb));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_bits("bp_in_ready_next", 64'(in_ready), 64'd1);
    check_bits("bp_out_valid_next", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat, rl);
    check_bits("bp_b_latency", 64'(lat), 64'd66);
    check_result("bp_b");
    release_out("bp_b");

    // Reset in the middle of RUN abandons the vector.
    for (int j = 0; j < NE; j++) v[j*CBW +: CBW] = $urandom;
    start_vec(v);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bits("abort_in_ready", 64'(in_ready), 64'd1);
    check_bits("abort_busy", 64'(busy), 64'd0);
    check_bits("abort_out_valid", 64'(out_valid), 64'd0);
    check_value("abort_out_value", out_value, '0);
    ok = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check_bits("abort_no_valid", 64'(ok), 64'd1);
    v = '0;
    v[1*CBW +: CBW] = 32'h0000_0005;
    do_run("post_abort", v);
    check_value("post_abort_const", out_value, OUT_W'(32'h0005_0000));
    release_out("post_abort");

    check_bits("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
